// File: rtl/camera_pkg.sv
// Shared types and constants for the camera readout path.
// Holds the readout FSM states, row identifiers and the row-select decoder.
package camera_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int NPIX       = 4;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_R1 = 2'd1,
    WAIT_R2 = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ROW_NONE = 2'd0,
    ROW_R1   = 2'd1,
    ROW_R2   = 2'd2
  } row_t;

  // Exactly one active-low row enable selects a row; anything else is ambiguous.
  function automatic row_t decode_row(input logic nre_r1, input logic nre_r2);
    row_t r;
    case ({nre_r1, nre_r2})
      2'b01:   r = ROW_R1;
      2'b10:   r = ROW_R2;
      default: r = ROW_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registers a strobe once and produces single-cycle rise/fall pulses.
// The pulses are combinational against the registered copy.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic lvl_d;
  logic lvl_q;

  always_comb begin
    lvl_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign rise = d & ~lvl_q;
  assign fall = ~d & lvl_q;

endmodule

// File: rtl/pixel_readout.sv
// Captures the two column samples of each row of a 2x2 pixel array and
// streams the completed frame out over a valid/ready handshake.
module pixel_readout
  import camera_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Erase,
  input  logic                  NRE_R1,
  input  logic                  NRE_R2,
  input  logic                  ADC,
  input  logic [2*DATA_W-1:0]   Col_data,
  output logic [DATA_W-1:0]     Pix_data,
  output logic                  Pix_valid,
  input  logic                  Pix_ready,
  output logic                  Pix_last,
  output logic                  Frame_done,
  output logic [1:0]            Err
);

  logic adc_rise, adc_fall;
  logic erase_rise, erase_fall;

  edge_detect u_adc_edge (
    .clk  (Clk),
    .rst  (Reset),
    .d    (ADC),
    .rise (adc_rise),
    .fall (adc_fall)
  );

  edge_detect u_erase_edge (
    .clk  (Clk),
    .rst  (Reset),
    .d    (Erase),
    .rise (erase_rise),
    .fall (erase_fall)
  );

  state_t             state_d, state_q;
  row_t               row_d, row_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [DATA_W-1:0]  pix_buf_d [NPIX];
  logic [DATA_W-1:0]  pix_buf_q [NPIX];
  logic [DATA_W-1:0]  pix_data_d, pix_data_q;
  logic               pix_valid_d, pix_valid_q;
  logic               pix_last_d, pix_last_q;
  logic               frame_done_d, frame_done_q;
  logic [1:0]         err_d, err_q;
  logic               hs;
  logic [DATA_W-1:0]  col1, col2;

  assign col1 = Col_data[DATA_W-1:0];
  assign col2 = Col_data[2*DATA_W-1:DATA_W];
  assign hs   = pix_valid_q & Pix_ready;

  // Next-state, capture and output-register logic for the readout FSM.
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    idx_d        = idx_q;
    pix_buf_d    = pix_buf_q;
    pix_data_d   = pix_data_q;
    pix_valid_d  = 1'b0;
    pix_last_d   = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err_q;

    if (adc_rise) begin
      row_d = decode_row(NRE_R1, NRE_R2);
    end else begin
      row_d = row_q;
    end

    case (state_q)
      IDLE: begin
        if (erase_rise) begin
          state_d = WAIT_R1;
          idx_d   = {IDX_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_R1: begin
        // Erase outranks a capture landing on the same edge.
        if (erase_rise) begin
          err_d[0] = 1'b1;
          state_d  = WAIT_R1;
          idx_d    = {IDX_W{1'b0}};
        end else if (adc_fall) begin
          if (row_q == ROW_R1) begin
            pix_buf_d[0] = col1;
            pix_buf_d[1] = col2;
            state_d      = WAIT_R2;
          end else begin
            err_d[1] = 1'b1;
          end
        end else begin
          state_d = WAIT_R1;
        end
      end
      WAIT_R2: begin
        if (erase_rise) begin
          err_d[0] = 1'b1;
          state_d  = WAIT_R1;
          idx_d    = {IDX_W{1'b0}};
        end else if (adc_fall) begin
          if (row_q == ROW_R2) begin
            pix_buf_d[2] = col1;
            pix_buf_d[3] = col2;
            idx_d        = {IDX_W{1'b0}};
            state_d      = DRAIN;
          end else begin
            err_d[1] = 1'b1;
          end
        end else begin
          state_d = WAIT_R2;
        end
      end
      DRAIN: begin
        // idx names the pixel presented on Pix_data once these registers load.
        if (erase_rise) begin
          err_d[0] = 1'b1;
          state_d  = WAIT_R1;
          idx_d    = {IDX_W{1'b0}};
        end else if (hs && (idx_q == IDX_W'(NPIX - 1))) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
          idx_d        = {IDX_W{1'b0}};
        end else begin
          if (hs) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = idx_q;
          end
          pix_valid_d = 1'b1;
          pix_data_d  = pix_buf_q[idx_d];
          pix_last_d  = (idx_d == IDX_W'(NPIX - 1));
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, buffer and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      row_q        <= ROW_NONE;
      idx_q        <= {IDX_W{1'b0}};
      pix_data_q   <= {DATA_W{1'b0}};
      pix_valid_q  <= 1'b0;
      pix_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 2'b00;
      for (int i = 0; i < NPIX; i++) begin
        pix_buf_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      idx_q        <= idx_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      pix_last_q   <= pix_last_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      for (int i = 0; i < NPIX; i++) begin
        pix_buf_q[i] <= pix_buf_d[i];
      end
    end
  end

  assign Pix_data   = pix_data_q;
  assign Pix_valid  = pix_valid_q;
  assign Pix_last   = pix_last_q;
  assign Frame_done = frame_done_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Randomized bench for pixel_readout, checked against a frame-level model
// of the readout rules (expected row, captured pixels, sticky errors).
module tb_pixel_readout;

  localparam int R_BOTH = 0;
  localparam int R_1    = 1;
  localparam int R_2    = 2;
  localparam int R_NONE = 3;

  logic        Clk = 1'b0;
  logic        Reset, Erase, NRE_R1, NRE_R2, ADC, Pix_ready;
  logic [15:0] Col_data;
  logic [7:0]  Pix_data;
  logic        Pix_valid, Pix_last, Frame_done;
  logic [1:0]  Err;

  int n_chk  = 0;
  int n_pass = 0;

  // Frame-level model: 0 idle, 1 expects row 1, 2 expects row 2, 3 frame ready.
  int         m_phase;
  logic [1:0] m_err;
  logic [7:0] m_px [4];

  pixel_readout #(.DATA_W(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Erase      (Erase),
    .NRE_R1     (NRE_R1),
    .NRE_R2     (NRE_R2),
    .ADC        (ADC),
    .Col_data   (Col_data),
    .Pix_data   (Pix_data),
    .Pix_valid  (Pix_valid),
    .Pix_ready  (Pix_ready),
    .Pix_last   (Pix_last),
    .Frame_done (Frame_done),
    .Err        (Err)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_erase();
    if (m_phase != 0) m_err[0] = 1'b1;
    m_phase = 1;
  endtask

  task automatic model_row(input int r, input logic [15:0] c);
    if (m_phase == 1) begin
      if (r == R_1) begin
        m_px[0] = c[7:0]; m_px[1] = c[15:8]; m_phase = 2;
      end else m_err[1] = 1'b1;
    end else if (m_phase == 2) begin
      if (r == R_2) begin
        m_px[2] = c[7:0]; m_px[3] = c[15:8]; m_phase = 3;
      end else m_err[1] = 1'b1;
    end
  endtask

  task automatic erase_pulse();
    Erase = 1'b1;
    step();
    model_erase();
    Erase = 1'b0;
    step();
  endtask

  // Ends 1 time unit after the capture edge.
  task automatic row_read(input int r, input logic [15:0] c, input int len);
    NRE_R1   = !(r == R_1 || r == R_BOTH);
    NRE_R2   = !(r == R_2 || r == R_BOTH);
    Col_data = c;
    step();
    ADC = 1'b1;
    repeat (len) step();
    ADC = 1'b0;
    step();
    model_row(r, c);
    NRE_R1   = 1'b1;
    NRE_R2   = 1'b1;
    Col_data = 16'($urandom);
  endtask

  // mode 0: always ready, 1: ready pattern 0,0,1 per pixel, 2: random ready.
  task automatic drain_frame(input int mode, input int n_take);
    int k = 0;
    int it = 0;
    int first = -1;
    int last = -1;
    int bp = 0;
    logic held = 1'b0;
    logic [7:0] prev = 8'h00;
    logic rdy;
    while (k < n_take && it < 100) begin
      if (it == 0) check("lat_capture", {31'd0, Pix_valid}, 32'd0);
      if (it == 1) check("lat_valid", {31'd0, Pix_valid}, 32'd1);
      if (held) begin
        check("hold_valid", {31'd0, Pix_valid}, 32'd1);
        check("hold_data", {24'd0, Pix_data}, {24'd0, prev});
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (bp == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      Pix_ready = rdy;
      if (Pix_valid && rdy) begin
        check("pix_data", {24'd0, Pix_data}, {24'd0, m_px[k]});
        check("pix_last", {31'd0, Pix_last}, {31'd0, (k == 3)});
        if (first < 0) first = it;
        last = it;
        k++;
        bp = 0;
      end else if (Pix_valid) begin
        bp++;
      end
      held = Pix_valid && !rdy;
      prev = Pix_data;
      step();
      it++;
    end
    if (k < n_take) check("drain_timeout", k, n_take);
    Pix_ready = 1'b0;
    if (n_take == 4) begin
      m_phase = 0;
      check("frame_done", {31'd0, Frame_done}, 32'd1);
      check("done_valid", {31'd0, Pix_valid}, 32'd0);
      step();
      check("done_pulse", {31'd0, Frame_done}, 32'd0);
      if (mode == 0) check("consecutive", last - first, 32'd3);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'd0, Pix_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, Pix_data}, 32'd0);
    check({tag, "_last"}, {31'd0, Pix_last}, 32'd0);
    check({tag, "_done"}, {31'd0, Frame_done}, 32'd0);
    check({tag, "_err"}, {30'd0, Err}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; Erase = 1'b0; NRE_R1 = 1'b1; NRE_R2 = 1'b1; ADC = 1'b0;
    Pix_ready = 1'b0; Col_data = 16'h0000;
    m_phase = 0; m_err = 2'b00;
    repeat (3) step();
    check_reset_outputs("reset");
    Reset = 1'b0;
    step();

    // Row strobes before any Erase are ignored without error.
    row_read(R_1, 16'h1122, 1);
    row_read(R_2, 16'h3344, 1);
    step();
    check("idle_valid", {31'd0, Pix_valid}, 32'd0);
    check("idle_err", {30'd0, Err}, {30'd0, m_err});

    // Normal frame.
    erase_pulse();
    row_read(R_1, 16'hB2A1, 2);
    row_read(R_2, 16'hD4C3, 1);
    drain_frame(0, 4);
    check("normal_err", {30'd0, Err}, {30'd0, m_err});

    // Backpressure.
    erase_pulse();
    row_read(R_1, 16'hB2A1, 2);
    row_read(R_2, 16'hD4C3, 1);
    drain_frame(1, 4);

    // Protocol violation in WAIT_R1, then a good frame.
    erase_pulse();
    row_read(R_2, 16'h5555, 1);
    row_read(R_BOTH, 16'h6666, 2);
    check("proto_err", {30'd0, Err}, {30'd0, m_err});
    check("proto_valid", {31'd0, Pix_valid}, 32'd0);
    row_read(R_1, 16'h2211, 1);
    row_read(R_2, 16'h4433, 1);
    drain_frame(2, 4);

    // Drop mid-drain; the next frame restarts at P11.
    erase_pulse();
    row_read(R_1, 16'h8877, 1);
    row_read(R_2, 16'hAA99, 1);
    drain_frame(0, 2);
    Erase = 1'b1;
    step();
    model_erase();
    Erase = 1'b0;
    check("drop_valid", {31'd0, Pix_valid}, 32'd0);
    check("drop_err", {30'd0, Err}, {30'd0, m_err});
    step();
    row_read(R_1, 16'hCCBB, 1);
    row_read(R_2, 16'hEEDD, 3);
    drain_frame(0, 4);

    // Randomized frames with occasional bad strobes and random backpressure.
    for (int f = 0; f < 20; f++) begin
      erase_pulse();
      if ($urandom_range(0, 3) == 0) begin
        int bad1 [3] = '{R_2, R_BOTH, R_NONE};
        row_read(bad1[$urandom_range(0, 2)], 16'($urandom), $urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 2)) step();
      row_read(R_1, 16'($urandom), $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        int bad2 [3] = '{R_1, R_BOTH, R_NONE};
        row_read(bad2[$urandom_range(0, 2)], 16'($urandom), $urandom_range(1, 3));
      end
      repeat ($urandom_range(0, 2)) step();
      row_read(R_2, 16'($urandom), $urandom_range(1, 3));
      drain_frame($urandom_range(0, 2), 4);
      check("rand_err", {30'd0, Err}, {30'd0, m_err});
    end

    // Asynchronous reset in the middle of a drain.
    erase_pulse();
    row_read(R_1, 16'h5A5A, 1);
    row_read(R_2, 16'hA5A5, 1);
    drain_frame(0, 1);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_outputs("async");
    m_phase = 0;
    m_err = 2'b00;
    step();
    Reset = 1'b0;
    step();
    row_read(R_1, 16'h0F0F, 1);
    row_read(R_2, 16'hF0F0, 1);
    step();
    check("post_reset_idle", {31'd0, Pix_valid}, 32'd0);
    check("post_reset_err", {30'd0, Err}, {30'd0, m_err});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Downstream stage of the camera control FSM. Watches the row-select strobes (NRE_R1, NRE_R2), the ADC conversion strobe and Erase produced by the control FSM. Captures the two column ADC results of each row of the 2x2 pixel array into a 4-entry frame buffer. Once a full frame is held, streams it out pixel by pixel over a valid/ready handshake.

## Interface
- DATA_W, 8, ADC sample width per column
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Erase  in  1  from control FSM; rising edge marks start of a new frame
- NRE_R1  in  1  active-low row 1 read enable
- NRE_R2  in  1  active-low row 2 read enable
- ADC  in  1  conversion strobe, high for ≥1 cycle per row
- Col_data  in  2*DATA_W  [DATA_W-1:0] = column 1, [2*DATA_W-1:DATA_W] = column 2; stable on the cycle ADC falls
- Pix_data  out  DATA_W  current output pixel
- Pix_valid  out  1  Pix_data valid
- Pix_ready  in  1  consumer accepts when Pix_valid & Pix_ready
- Pix_last  out  1  high with 4th pixel (P22)
- Frame_done  out  1  one-cycle pulse after last pixel accepted
- Err  out  2  sticky: [0] frame dropped, [1] strobe protocol violation

## Operation
- Edge detect: ADC and Erase registered once; rise = in & ~q, fall = ~in & q.
- Row latch: on ADC rise, record row = R1 if NRE_R1=0 & NRE_R2=1, R2 if NRE_R2=0 & NRE_R1=1, else NONE.
- Capture: on ADC fall, Col_data written to buffer if latched row matches state; otherwise ignored and Err[1] set.
- States: IDLE, WAIT_R1, WAIT_R2, DRAIN.
- IDLE: Erase rise -> WAIT_R1. ADC activity ignored, no error.
- WAIT_R1: valid R1 capture -> buf[0]=col1, buf[1]=col2, -> WAIT_R2. R2 or NONE capture -> Err[1], stay.
- WAIT_R2: valid R2 capture -> buf[2]=col1, buf[3]=col2, idx=0, -> DRAIN. R1 or NONE capture -> Err[1], stay.
- DRAIN: Pix_valid=1, Pix_data=buf[idx], Pix_last=(idx==3). On handshake, idx++. Handshake at idx 3 -> Frame_done pulse, -> IDLE.
- Erase rise in WAIT_R1/WAIT_R2/DRAIN: partial or undelivered frame discarded, Err[0] set, -> WAIT_R1, idx=0.
  - Pix_valid is withdrawn even without handshake; this is the only permitted valid drop.
- Erase rise and ADC fall in the same cycle: Erase wins, capture discarded.
- Err bits clear only on Reset.
- Output order is fixed: P11, P12, P21, P22.

## Timing
- Reset values: Pix_valid=0, Pix_data=0, Pix_last=0, Frame_done=0, Err=0, state=IDLE, idx=0, buffer=0.
- Erase rise seen one cycle after Erase goes high; state changes on that edge.
- Capture occurs on the Clk edge where ADC is first sampled low after being high. Col_data is sampled from that same cycle.
- Pix_valid rises on the edge after the row 2 capture edge (1-cycle latency).
- Pix_data and Pix_last are held stable while Pix_valid=1 and Pix_ready=0.
- With Pix_ready held high, the 4 pixels occupy 4 consecutive cycles.
- Frame_done is registered and high on the cycle after the last handshake, concurrent with Pix_valid=0.
- All outputs are registered; no combinational path from Pix_ready to Pix_valid.

## Structure
- camera_pkg: typedef enum of the 4 states; constants DATA_W default, NPIX=4, IDX_W=2.
- Sub-module edge_detect: 1-bit register plus rise/fall pulse outputs, instanced for ADC and Erase.
- Buffer: 4 x DATA_W register array inside pixel_readout.

## Test plan
- Normal frame:
  - Stimulus: Erase pulse; NRE_R1=0, ADC high 2 cycles, Col_data=16'hB2A1; NRE_R2=0, ADC pulse, Col_data=16'hD4C3; Pix_ready=1.
  - Required: Pix_data A1,B2,C3,D4 on consecutive cycles; Pix_last on D4; Frame_done 1 cycle after; Err=0.
- Backpressure:
  - Stimulus: same frame, Pix_ready toggled 0,0,1 per pixel.
  - Required: each value held stable for 3 cycles; no loss or reorder.
- Protocol violation:
  - Stimulus: in WAIT_R1, ADC pulse with NRE_R2=0, then with both NRE low.
  - Required: Err[1]=1, state stays WAIT_R1; a following valid R1/R2 frame still streams correctly.
- Drop:
  - Stimulus: Erase rise during DRAIN after 2 pixels accepted.
  - Required: Pix_valid=0 next cycle, Err[0]=1; the next frame starts at P11.
- Async reset:
  - Stimulus: Reset asserted mid-DRAIN between clock edges.
  - Required: all outputs go to reset values immediately, without waiting for Clk; state IDLE.
